// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU op codes, forward selects, multiplier FSM encoding,
// the EX/MEM record layout and the operand-mux / ALU helper functions.
package ex_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned MUL_ITER = 32;
    localparam logic [5:0]  MUL_LAST = 6'(MUL_ITER - 1);

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        zero;
    } ex_mem_t;

    // Code 11 is unused by the forwarding unit and falls back to the register file.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] exm, input logic [31:0] mwb);
        logic [31:0] v;
        case (sel)
            FWD_EXMEM: v = exm;
            FWD_MEMWB: v = mwb;
            default:   v = rf;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] alu_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            default: r = 32'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multu_seq.sv
// 32-step shift-add unsigned multiplier (low 32 bits of the product), IDLE -> BUSY -> DONE.
// Only compiled when EX_STAGE_MULTU_EN is defined.
`ifdef EX_STAGE_MULTU_EN
module multu_seq
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 32'b0;
                    cnt_d    = 6'd0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == MUL_LAST) begin
                    state_d = ST_DONE;
                end
            end
            // DONE always returns to IDLE so a held start cannot chain a new multiply here.
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            mcand_q  <= 32'b0;
            mplier_q <= 32'b0;
            acc_q    <= 32'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy    = (state_q == ST_BUSY);
    assign done    = (state_q == ST_DONE);
    assign product = acc_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Pipeline EX stage: forwarding muxes, single-cycle ALU and the EX/MEM register.
// Define EX_STAGE_MULTU_EN to add the stalling sequential MULTU unit.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ctrl_in,
    input  logic [3:0]  alu_ctrl_in,
    input  logic        alu_src_in,
    input  logic [31:0] rs_data_in,
    input  logic [31:0] rt_data_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rd_in,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] mem_wb_result,
    output logic [3:0]  ctrl_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_out,
    output logic        zero_out,
    output logic        stall_out
);

    logic [31:0] op_a, rt_fwd, op_b, alu_res, final_res;
    logic        stall, mul_done;
    logic [31:0] mul_prod;
    ex_mem_t     exm_q, exm_d;

    assign op_a    = fwd_mux(forwardA, rs_data_in, ex_mem_result, mem_wb_result);
    assign rt_fwd  = fwd_mux(forwardB, rt_data_in, ex_mem_result, mem_wb_result);
    assign op_b    = alu_src_in ? imm_in : rt_fwd;
    assign alu_res = alu_op(alu_ctrl_in, op_a, op_b);

`ifdef EX_STAGE_MULTU_EN
    logic is_multu, mul_busy;

    assign is_multu = (alu_ctrl_in == OP_MULTU);

    multu_seq u_multu (
        .clk     (clk),
        .rst     (rst),
        .start   (is_multu),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Stall covers the accept cycle (IDLE with MULTU) plus every BUSY cycle.
    assign stall = ~rst & (mul_busy | (is_multu & ~mul_done));
`else
    assign stall    = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = 32'b0;
`endif

    assign final_res = mul_done ? mul_prod : alu_res;

    always_comb begin
        exm_d       = '0;
        exm_d.store = rt_fwd;
        if (!stall) begin
            exm_d.ctrl   = ctrl_in;
            exm_d.result = final_res;
            exm_d.rd     = rd_in;
            exm_d.zero   = (final_res == 32'b0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exm_q <= '0;
        end else begin
            exm_q <= exm_d;
        end
    end

    assign ctrl_out       = exm_q.ctrl;
    assign alu_result_out = exm_q.result;
    assign store_data_out = exm_q.store;
    assign rd_out         = exm_q.rd;
    assign zero_out       = exm_q.zero;
    assign stall_out      = stall;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized model comparison,
// async reset and (when EX_STAGE_MULTU_EN is defined) MULTU stall/abort sequences.
`timescale 1ns/1ps
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ctrl_in, alu_ctrl_in;
    logic        alu_src_in;
    logic [31:0] rs_data_in, rt_data_in, imm_in;
    logic [4:0]  rd_in;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] ex_mem_result, mem_wb_result;
    logic [3:0]  ctrl_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  rd_out;
    logic        zero_out, stall_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .alu_ctrl_in(alu_ctrl_in),
        .alu_src_in(alu_src_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
        .imm_in(imm_in), .rd_in(rd_in), .forwardA(forwardA), .forwardB(forwardB),
        .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
        .ctrl_out(ctrl_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .rd_out(rd_out), .zero_out(zero_out),
        .stall_out(stall_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] rs, rt, imm;
        logic [1:0]  fa, fb;
        logic [31:0] exm, mwb;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [31:0] exp_store;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] op, logic src, logic [31:0] rs, logic [31:0] rt,
                                logic [31:0] imm, logic [1:0] fa, logic [1:0] fb,
                                logic [31:0] exm, logic [31:0] mwb, logic [3:0] ctrl,
                                logic [4:0] rd, logic [31:0] exp_res, logic exp_zero,
                                logic [31:0] exp_store);
        vec_t v;
        v.op = op; v.src = src; v.rs = rs; v.rt = rt; v.imm = imm; v.fa = fa; v.fb = fb;
        v.exm = exm; v.mwb = mwb; v.ctrl = ctrl; v.rd = rd; v.exp_res = exp_res;
        v.exp_zero = exp_zero; v.exp_store = exp_store;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_ctrl_in   = v.op;   alu_src_in    = v.src;
        rs_data_in    = v.rs;   rt_data_in    = v.rt;  imm_in = v.imm;
        forwardA      = v.fa;   forwardB      = v.fb;
        ex_mem_result = v.exm;  mem_wb_result = v.mwb;
        ctrl_in       = v.ctrl; rd_in         = v.rd;
    endtask

    // Reference model: the operation rules expressed with wide integer arithmetic.
    function automatic longint sval(logic [31:0] x);
        return x[31] ? longint'(x) - 64'sd4294967296 : longint'(x);
    endfunction

    function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] rf, logic [31:0] exm,
                                         logic [31:0] mwb);
        if (sel == 2'b10) return exm;
        if (sel == 2'b01) return mwb;
        return rf;
    endfunction

    function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint s;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  begin s = longint'(a) + longint'(b); return s[31:0]; end
            4'd6:  begin s = longint'(a) - longint'(b); return s[31:0]; end
            4'd12: return ~(a | b);
            4'd7:  return (sval(a) < sval(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, "_result"}, alu_result_out, v.exp_res);
        chk({tag, "_zero"},   {31'b0, zero_out}, {31'b0, v.exp_zero});
        chk({tag, "_ctrl"},   {28'b0, ctrl_out}, {28'b0, v.ctrl});
        chk({tag, "_rd"},     {27'b0, rd_out}, {27'b0, v.rd});
        chk({tag, "_store"},  store_data_out, v.exp_store);
    endtask

    initial begin
        vec_t v;
        logic [3:0] ops[8];
        logic [31:0] a, bv, r;
        int nstall;
        bit done_seen;

        rst = 1'b1;
        drive(mk(4'd2, 1'b0, 32'd1, 32'd2, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 4'hF, 5'd3,
                 32'd0, 1'b0, 32'd0));
        #1;
        chk("reset_result", alu_result_out, 32'd0);
        chk("reset_ctrl",   {28'b0, ctrl_out}, 32'd0);
        chk("reset_stall",  {31'b0, stall_out}, 32'd0);
        @(posedge clk); #1;
        chk("reset_hold_rd",    {27'b0, rd_out}, 32'd0);
        chk("reset_hold_store", store_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(mk(4'b0010, 0, 32'd5, 32'd7, 32'd0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd1, 32'd12, 0, 32'd7));
        vecs.push_back(mk(4'b0110, 0, 32'd1, 32'd2, 32'd0, 2'b10, 2'b01, 32'd9, 32'd9, 4'b1001, 5'd2, 32'd0, 1, 32'd9));
        vecs.push_back(mk(4'b0111, 1, 32'hFFFFFFFF, 32'h55, 32'd1, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd3, 32'd1, 0, 32'h55));
        vecs.push_back(mk(4'b0010, 1, 32'd3, 32'd8, 32'd4, 2'b11, 2'b11, 32'd100, 32'd200, 4'b0100, 5'd4, 32'd7, 0, 32'd8));
        vecs.push_back(mk(4'b0000, 0, 32'hF0F0, 32'hFF00, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd5, 32'hF000, 0, 32'hFF00));
        vecs.push_back(mk(4'b0001, 0, 32'hF0F0, 32'hFF00, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd6, 32'hFFF0, 0, 32'hFF00));
        vecs.push_back(mk(4'b1100, 0, 32'd0, 32'd0, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd7, 32'hFFFFFFFF, 0, 32'd0));
        vecs.push_back(mk(4'b0111, 0, 32'd5, 32'hFFFFFFFE, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd8, 32'd0, 1, 32'hFFFFFFFE));
        vecs.push_back(mk(4'b0011, 0, 32'd5, 32'd5, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd9, 32'd0, 1, 32'd5));
        vecs.push_back(mk(4'b0010, 0, 32'hFFFFFFFF, 32'd1, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd10, 32'd0, 1, 32'd1));
        vecs.push_back(mk(4'b0110, 0, 32'd0, 32'd0, 0, 2'b01, 2'b10, 32'd3, 32'd10, 4'b0011, 5'd31, 32'd7, 0, 32'd3));
`ifndef EX_STAGE_MULTU_EN
        vecs.push_back(mk(4'b1001, 0, 32'd6, 32'd7, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd11, 32'd0, 1, 32'd7));
`endif

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_stall", i), {31'b0, stall_out}, 32'd0);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
            $display("vec %0d op=%b result=%h zero=%0d", i, vecs[i].op, alu_result_out, zero_out);
        end

        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd7, 4'd7, 4'd6};
        for (int i = 0; i < 40; i++) begin
            v.op = (i % 4 == 3) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)];
`ifdef EX_STAGE_MULTU_EN
            if (v.op == 4'b1001) v.op = 4'b0010;
`endif
            v.src = 1'($urandom);
            v.rs  = $urandom;
            v.rt  = (i % 5 == 0) ? v.rs : $urandom;
            v.imm = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            v.fa  = 2'($urandom);   v.fb  = 2'($urandom);
            v.exm = $urandom;       v.mwb = (i % 6 == 0) ? v.exm : $urandom;
            v.ctrl = 4'($urandom);  v.rd  = 5'($urandom);
            a  = pick(v.fa, v.rs, v.exm, v.mwb);
            v.exp_store = pick(v.fb, v.rt, v.exm, v.mwb);
            bv = v.src ? v.imm : v.exp_store;
            r  = model(v.op, a, bv);
            v.exp_res  = r;
            v.exp_zero = (r == 32'd0);
            drive(v);
            @(posedge clk); #1;
            check_outputs($sformatf("rnd%0d", i), v);
            $display("rnd %0d op=%b result=%h", i, v.op, alu_result_out);
        end

        // Asynchronous reset takes effect mid-cycle, without a clock edge.
        drive(mk(4'b0010, 0, 32'd20, 32'd22, 0, 2'b00, 2'b00, 0, 0, 4'b1111, 5'd17, 32'd42, 0, 32'd22));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_result", alu_result_out, 32'd0);
        chk("async_rst_ctrl",   {28'b0, ctrl_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("async reset sequence done");

`ifdef EX_STAGE_MULTU_EN
        // MULTU 6x7 with ex_mem_result changed after acceptance.
        drive(mk(4'b1001, 0, 32'd0, 32'd7, 0, 2'b10, 2'b00, 32'd6, 0, 4'b1010, 5'd9, 0, 0, 0));
        #1;
        chk("mul_accept_stall", {31'b0, stall_out}, 32'd1);
        nstall = 0;
        done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (stall_out) begin
                nstall++;
                @(posedge clk); #1;
                ex_mem_result = 32'h123;
                chk("mul_bubble_ctrl",   {28'b0, ctrl_out}, 32'd0);
                chk("mul_bubble_result", alu_result_out, 32'd0);
                chk("mul_bubble_rd",     {27'b0, rd_out}, 32'd0);
                chk("mul_bubble_zero",   {31'b0, zero_out}, 32'd0);
            end else begin
                done_seen = 1;
            end
        end
        chk("mul_done_reached", {31'b0, done_seen}, 32'd1);
        chk("mul_stall_cycles", nstall, 32'd33);
        ex_mem_result = 32'hFFFFFFFF;
        rt_data_in    = 32'd2;
        @(posedge clk); #1;
        chk("mul_result", alu_result_out, 32'd42);
        chk("mul_ctrl",   {28'b0, ctrl_out}, 32'h0000000A);
        chk("mul_rd",     {27'b0, rd_out}, 32'd9);
        chk("mul_zero",   {31'b0, zero_out}, 32'd0);
        chk("mul_reaccept_stall", {31'b0, stall_out}, 32'd1);
        $display("multu 6x7 result=%0d stall_cycles=%0d", alu_result_out, nstall);

        // Second MULTU (0xFFFFFFFF x 2) is abandoned by reset in BUSY cycle 10.
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mul_rst_stall",  {31'b0, stall_out}, 32'd0);
        chk("mul_rst_result", alu_result_out, 32'd0);
        chk("mul_rst_ctrl",   {28'b0, ctrl_out}, 32'd0);
        chk("mul_rst_rd",     {27'b0, rd_out}, 32'd0);
        chk("mul_rst_store",  store_data_out, 32'd0);
        drive(mk(4'b0010, 0, 32'd5, 32'd7, 0, 2'b00, 2'b00, 0, 0, 4'b1000, 5'd12, 32'd12, 0, 32'd7));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            chk("post_rst_add_result", alu_result_out, 32'd12);
            chk("post_rst_add_stall",  {31'b0, stall_out}, 32'd0);
        end
        $display("multu abort then add result=%0d", alu_result_out);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-003 SHALL have port ctrl_in, input, 4 bits: {RegWrite, MemRead, MemWrite, MemtoReg} from the ID/EX register.
REQ-004 SHALL have port alu_ctrl_in, input, 4 bits: operation code, listed in REQ-013.
REQ-005 SHALL have port alu_src_in, input, 1 bit: 1 selects imm_in as operand B, 0 selects the forwarded rt value.
REQ-006 SHALL have ports rs_data_in, rt_data_in and imm_in, inputs, 32 bits each: register-file operands and the sign-extended immediate.
REQ-007 SHALL have port rd_in, input, 5 bits: destination register number, already selected.
REQ-008 SHALL have ports forwardA and forwardB, inputs, 2 bits each: operand-source selects from the forwarding unit.
REQ-009 SHALL have ports ex_mem_result and mem_wb_result, inputs, 32 bits each: the forwarding data paths.
REQ-010 SHALL have outputs ctrl_out (4 bits), alu_result_out (32 bits), store_data_out (32 bits), rd_out (5 bits) and zero_out (1 bit): the EX/MEM register.
REQ-011 SHALL have output stall_out, 1 bit: while high, upstream stages hold PC, IF/ID and ID/EX.

Function
REQ-012 Operand select: forward code 10 -> ex_mem_result; 01 -> mem_wb_result; 00 or 11 -> the register-file value.
- Operand A uses forwardA with rs_data_in.
- The rt value uses forwardB with rt_data_in.
- Operand B = alu_src_in ? imm_in : rt value.
- store_data_out always takes the forwarded rt value.
REQ-013 Operations, 32-bit wrap-around arithmetic:
- AND=0000, OR=0001, ADD=0010, SUB=0110, NOR=1100.
- SLT=0111: signed compare, result 1 or 0.
- MULTU=1001: low 32 bits of the unsigned product.
- Any other code yields result 0.
REQ-014 Single-cycle operations SHALL register in EX/MEM on the next rising edge, with latency 1.
- ctrl_out=ctrl_in, rd_out=rd_in.
- zero_out=1 when the result is 0.
REQ-015 The MULTU state machine SHALL have states IDLE, BUSY and DONE.
REQ-016 IDLE with alu_ctrl_in=MULTU:
- Latch both selected operands.
- Clear the 6-bit counter.
- Move to BUSY.
- stall_out=1 combinationally in the same cycle.
REQ-017 BUSY SHALL perform one shift-add step per cycle with stall_out=1.
- The counter increments each step.
- After step 32, move to DONE.
REQ-018 DONE SHALL drive stall_out=0 and register the product with ctrl_in/rd_in into EX/MEM, then return to IDLE.
- Total: exactly 33 stall cycles per MULTU.
REQ-019 While stall_out=1, EX/MEM SHALL load a bubble: ctrl_out=0000, alu_result_out=0, rd_out=0, zero_out=0.
REQ-020 Operands latched at acceptance SHALL be used throughout, regardless of later changes on the forward inputs.
REQ-021 In DONE, a MULTU still held on alu_ctrl_in SHALL NOT restart the state machine.
- A new MULTU is accepted in the following IDLE cycle.

Reset
REQ-022 rst high SHALL immediately force:
- state=IDLE, counter=0, stall_out=0.
- ctrl_out=0, alu_result_out=0, store_data_out=0, rd_out=0, zero_out=0.
REQ-023 Reset during BUSY SHALL abandon the multiply, with no partial result ever written.

Configuration
REQ-024 Macro EX_STAGE_MULTU_EN defined: REQ-015 to REQ-021 are included.
REQ-025 Macro EX_STAGE_MULTU_EN undefined:
- No state machine is built.
- stall_out is tied to 0.
- MULTU is treated as an unknown code (result 0, latency 1).

Structure
REQ-026 Shared package ex_pkg SHALL hold:
- the ALU operation codes;
- the forward-select codes 00/01/10;
- the multiplier state encoding and the iteration count 32.
REQ-027 The sequential multiplier SHALL be the sub-module multu_seq, with start, a, b, busy, done and product ports.

Verification
REQ-028 ADD, rs=5, rt=7, forwardA/B=00 -> next edge: alu_result_out=12, zero_out=0.
REQ-029 SUB, forwardA=10, ex_mem_result=9, forwardB=01, mem_wb_result=9 -> alu_result_out=0, zero_out=1.
REQ-030 SLT with A=0xFFFFFFFF and B=1 -> result 1; forwardA=11 with rs=3 -> rs value 3 is used.
REQ-031 MULTU 6x7, then change ex_mem_result during the stall:
- stall_out high for exactly 33 cycles, bubbles in EX/MEM.
- alu_result_out=42 after DONE.
REQ-032 MULTU 0xFFFFFFFF x 2, rst asserted in BUSY cycle 10:
- Immediately stall_out=0 and all outputs 0.
- A new ADD after reset completes normally.
